regfile_access_scheduler: RTL and testbench
===========================================

// Module: regfile_access_scheduler
// PURPOSE
// Shares the single 8x10-bit register file (one read pair rs1/rs2, one write port ws/wd, strobes rf/wf)
// between two requesters (req0 = execute unit, req1 = load/debug unit). Round-robin arbitration,
// one transaction in flight, fixed 3-cycle accept-to-response sequence. Drives all register-file
// inputs and registers rd1/rd2 before returning them to the winning requester.
// PARAMETERS
// DATA_W      10  register data width (matches register file wd/rd1/rd2)
// ADDR_W      3   register index width (8 registers)
// R0_READONLY 1   1: writes to R0 are acknowledged but suppressed (wf held 0), wr_err pulsed
// PORTS
// clk          in   1       clock, all state updates on rising edge
// reset        in   1       asynchronous, active-high reset
// reqN_valid   in   1       N=0,1: request present; must hold with fields stable until accepted
// reqN_ready   out  1       accept strobe; transfer when reqN_valid & reqN_ready
// reqN_we      in   1       1 = write (ws/wd used), 0 = read (rs1/rs2 used)
// reqN_rs1     in   ADDR_W  read address A
// reqN_rs2     in   ADDR_W  read address B
// reqN_ws      in   ADDR_W  write address
// reqN_wd      in   DATA_W  write data
// respN_valid  out  1       one-cycle response pulse to requester N (read data or write ack)
// resp_rd1     out  DATA_W  read data A (shared by both requesters, qualify with respN_valid)
// resp_rd2     out  DATA_W  read data B
// wr_err       out  1       one-cycle pulse with resp when a write to R0 was suppressed
// rf_rs1,rf_rs2,rf_ws out ADDR_W  register file addresses
// rf_wd        out  DATA_W  register file write data
// rf_rf,rf_wf  out  1       register file read / write strobes (never both 1)
// rf_rd1,rf_rd2 in  DATA_W  register file read data (combinational from rf_rs1/rf_rs2)
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, priority ptr=req0, all outputs 0, captured txn dropped.
// - FSM: IDLE -> ACCESS -> RESP -> IDLE. No backpressure on responses.
// - IDLE: grant chosen combinationally: only one valid -> it; both valid -> requester at ptr.
//   reqN_ready=1 only for the granted requester, only in IDLE. On accept (cycle T) latch fields,
//   grant id, and we; ptr <= other requester; go ACCESS. No valid -> stay IDLE, ready=0.
// - ACCESS (T+1): drive rf_rs1/rf_rs2/rf_ws/rf_wd from latched fields, exactly one-cycle strobe:
//   read -> rf_rf=1; write -> rf_wf=1 (rf_wf=0 if R0_READONLY && ws==0). Read data captured
//   into resp_rd1/resp_rd2 at end of ACCESS. Go RESP.
// - RESP (T+2): respN_valid=1 for latched id only; resp_rd* hold captured data (write: hold prior
//   values); wr_err=1 iff suppressed write. Go IDLE. Next accept earliest at T+3 (throughput 1/3).
// - Outside ACCESS: rf_rf=rf_wf=0, rf addresses/data hold last driven values.
// - Fairness: with both valid continuously, grants strictly alternate; one requester never waits
//   more than one transaction of the other.
// - A requester deasserting valid before accept is legal; it is simply not granted.
// - Reset during ACCESS/RESP: strobes and resp pulse drop immediately, no response delivered.
// - Read-after-write by the other requester sees new value (write completes in ACCESS before next accept).
// TESTING
// 1 Reset: assert reset mid-ACCESS of a write -> rf_wf drops to 0 same cycle, no resp0_valid, ready=0.
// 2 Single read: req0 rs1=1,rs2=2 (R1=2,R2=4) -> rf_rf=1 at T+1, resp0_valid at T+2, rd1=2, rd2=4.
// 3 Write then read: req1 write R3=0x155, then req0 read rs1=3 -> resp0 rd1=0x155, rf_wf pulse 1 cycle.
// 4 Contention: both valid 6 txns each from reset -> grant order 0,1,0,1,..., accepts every 3 cycles.
// 5 R0 protect: req0 write ws=0 wd=0x3FF -> rf_wf stays 0, resp0_valid=1 with wr_err=1; read R0 -> 0.
// 6 Withdrawal: req1 valid 1 cycle during ACCESS then low -> never granted, no resp1_valid.

Source files
------------

// File: rtl/regfile_access_scheduler.sv
// Round-robin scheduler sharing one 8-entry register file between two requesters.
// One transaction in flight: IDLE (accept) -> ACCESS (rf strobe) -> RESP (response pulse).
module regfile_access_scheduler #(
    parameter int unsigned DATA_W      = 10,
    parameter int unsigned ADDR_W      = 3,
    parameter bit          R0_READONLY = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_rs1,
    input  logic [ADDR_W-1:0] req0_rs2,
    input  logic [ADDR_W-1:0] req0_ws,
    input  logic [DATA_W-1:0] req0_wd,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_rs1,
    input  logic [ADDR_W-1:0] req1_rs2,
    input  logic [ADDR_W-1:0] req1_ws,
    input  logic [DATA_W-1:0] req1_wd,
    output logic              resp0_valid,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp_rd1,
    output logic [DATA_W-1:0] resp_rd2,
    output logic              wr_err,
    output logic [ADDR_W-1:0] rf_rs1,
    output logic [ADDR_W-1:0] rf_rs2,
    output logic [ADDR_W-1:0] rf_ws,
    output logic [DATA_W-1:0] rf_wd,
    output logic              rf_rf,
    output logic              rf_wf,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

    state_t state;
    logic   ptr;      // requester favoured when both are valid
    logic   txn_id;
    logic   txn_we;
    logic   txn_sup;  // write to R0 suppressed

    logic              gnt_any;
    logic              gnt_id;
    logic              sel_we;
    logic              sel_sup;
    logic [ADDR_W-1:0] sel_rs1;
    logic [ADDR_W-1:0] sel_rs2;
    logic [ADDR_W-1:0] sel_ws;
    logic [DATA_W-1:0] sel_wd;

    always_comb begin
        gnt_any = req0_valid | req1_valid;
        gnt_id  = (req0_valid & req1_valid) ? ptr : req1_valid;
        sel_we  = gnt_id ? req1_we  : req0_we;
        sel_rs1 = gnt_id ? req1_rs1 : req0_rs1;
        sel_rs2 = gnt_id ? req1_rs2 : req0_rs2;
        sel_ws  = gnt_id ? req1_ws  : req0_ws;
        sel_wd  = gnt_id ? req1_wd  : req0_wd;
        sel_sup = sel_we & R0_READONLY & (sel_ws == '0);
    end

    // Ready is held low while reset is asserted so nothing looks accepted.
    assign req0_ready = (state == StIdle) & ~reset & gnt_any & ~gnt_id;
    assign req1_ready = (state == StIdle) & ~reset & gnt_any &  gnt_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            ptr         <= 1'b0;
            txn_id      <= 1'b0;
            txn_we      <= 1'b0;
            txn_sup     <= 1'b0;
            rf_rs1      <= '0;
            rf_rs2      <= '0;
            rf_ws       <= '0;
            rf_wd       <= '0;
            rf_rf       <= 1'b0;
            rf_wf       <= 1'b0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp_rd1    <= '0;
            resp_rd2    <= '0;
            wr_err      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (gnt_any) begin
                        txn_id  <= gnt_id;
                        txn_we  <= sel_we;
                        txn_sup <= sel_sup;
                        rf_rs1  <= sel_rs1;
                        rf_rs2  <= sel_rs2;
                        rf_ws   <= sel_ws;
                        rf_wd   <= sel_wd;
                        rf_rf   <= ~sel_we;
                        rf_wf   <= sel_we & ~sel_sup;
                        ptr     <= ~gnt_id;
                        state   <= StAccess;
                    end
                end
                StAccess: begin
                    rf_rf <= 1'b0;
                    rf_wf <= 1'b0;
                    if (!txn_we) begin
                        resp_rd1 <= rf_rd1;
                        resp_rd2 <= rf_rd2;
                    end
                    resp0_valid <= ~txn_id;
                    resp1_valid <= txn_id;
                    wr_err      <= txn_sup;
                    state       <= StResp;
                end
                StResp: begin
                    resp0_valid <= 1'b0;
                    resp1_valid <= 1'b0;
                    wr_err      <= 1'b0;
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_scheduler.sv
// Scoreboard bench: issue tasks push expected responses, a monitor pops them on each resp pulse.
module tb_regfile_access_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
    logic [2:0] req0_rs1 = 0, req0_rs2 = 0, req0_ws = 0, req1_rs1 = 0, req1_rs2 = 0, req1_ws = 0;
    logic [9:0] req0_wd = 0, req1_wd = 0;
    logic       req0_ready, req1_ready, resp0_valid, resp1_valid, wr_err, rf_rf, rf_wf;
    logic [9:0] resp_rd1, resp_rd2, rf_wd, rf_rd1, rf_rd2;
    logic [2:0] rf_rs1, rf_rs2, rf_ws;

    regfile_access_scheduler dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_ws(req0_ws), .req0_wd(req0_wd),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_ws(req1_ws), .req1_wd(req1_wd),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp_rd1(resp_rd1), .resp_rd2(resp_rd2), .wr_err(wr_err),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_ws(rf_ws), .rf_wd(rf_wd),
        .rf_rf(rf_rf), .rf_wf(rf_wf), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
    );

    always #5 clk = ~clk;

    // Register file model, R[i] = 2*i initially.
    logic [9:0] rf_mem [8];
    initial for (int i = 0; i < 8; i++) rf_mem[i] = 10'(2 * i);
    always @(posedge clk) if (rf_wf) rf_mem[rf_ws] <= rf_wd;
    assign rf_rd1 = rf_mem[rf_rs1];
    assign rf_rd2 = rf_mem[rf_rs2];

    typedef struct packed {
        logic [9:0] rd1;
        logic [9:0] rd2;
        logic       err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   acc_id[$];
    int   acc_cyc[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cmp_resp(input string name, input exp_t e);
        chk(name, {resp_rd1, resp_rd2, wr_err}, {e.rd1, e.rd2, e.err});
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (!reset) begin
            if (resp0_valid && resp1_valid) chk("resp_both", 32'd1, 32'd0);
            if (rf_rf && rf_wf) chk("strobe_both", 32'd1, 32'd0);
            if (resp0_valid) begin
                if (q0.size() == 0) chk("resp0_unexpected", 32'd1, 32'd0);
                else cmp_resp("resp0", q0.pop_front());
            end
            if (resp1_valid) begin
                if (q1.size() == 0) chk("resp1_unexpected", 32'd1, 32'd0);
                else cmp_resp("resp1", q1.pop_front());
            end
            if (req0_valid && req0_ready) begin acc_id.push_back(0); acc_cyc.push_back(cyc); end
            if (req1_valid && req1_ready) begin acc_id.push_back(1); acc_cyc.push_back(cyc); end
        end
    end

    // Issue one request, wait for accept, check the ACCESS and RESP strobes.
    task automatic issue(input int n, input logic we, input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [2:0] ws, input logic [9:0] wd,
                         input logic [9:0] e1, input logic [9:0] e2, input logic eerr);
        int   waited = 0;
        bit   ok = 1'b0;
        exp_t e;
        e = '{rd1: e1, rd2: e2, err: eerr};
        if (n == 0) begin
            req0_we = we; req0_rs1 = rs1; req0_rs2 = rs2; req0_ws = ws; req0_wd = wd;
            req0_valid = 1'b1;
        end else begin
            req1_we = we; req1_rs1 = rs1; req1_rs2 = rs2; req1_ws = ws; req1_wd = wd;
            req1_valid = 1'b1;
        end
        while (waited < 30) begin
            @(negedge clk);
            if ((n == 0) ? req0_ready : req1_ready) begin ok = 1'b1; break; end
            waited++;
        end
        if (!ok) begin
            chk($sformatf("accept_timeout_req%0d", n), 32'd0, 32'd1);
            if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
            return;
        end
        if (n == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk); #1;
        if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        chk("access_rf", {31'd0, rf_rf}, {31'd0, !we});
        chk("access_wf", {31'd0, rf_wf}, {31'd0, we && (ws != 3'd0)});
        @(posedge clk); #1;
        chk("resp_strobes", {30'd0, rf_rf, rf_wf}, 32'd0);
    endtask

    task automatic wait_ready0(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req0_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit ok;
        #2;
        chk("rst_outputs", {req0_ready, req1_ready, resp0_valid, resp1_valid, wr_err, rf_rf, rf_wf},
            7'd0);
        chk("rst_data", {resp_rd1, resp_rd2, rf_wd}, 30'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Reset in the middle of a write's ACCESS cycle.
        req0_we = 1'b1; req0_ws = 3'd5; req0_wd = 10'h2AA; req0_valid = 1'b1;
        wait_ready0(ok);
        @(posedge clk); #1;
        chk("t1_wf_before", {31'd0, rf_wf}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t1_wf_drop", {31'd0, rf_wf}, 32'd0);
        chk("t1_ready_low", {30'd0, req0_ready, resp0_valid}, 32'd0);
        @(posedge clk); #1 req0_valid = 1'b0; req0_we = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("t1_r5_kept", {22'd0, rf_mem[5]}, 32'd10);

        // Single read, write then read by other requester, R0 protection.
        issue(0, 1'b0, 3'd1, 3'd2, 3'd0, 10'd0,   10'd2,   10'd4, 1'b0);
        issue(1, 1'b1, 3'd0, 3'd0, 3'd3, 10'h155, 10'd2,   10'd4, 1'b0);
        issue(0, 1'b0, 3'd3, 3'd0, 3'd0, 10'd0,   10'h155, 10'd0, 1'b0);
        issue(0, 1'b1, 3'd0, 3'd0, 3'd0, 10'h3FF, 10'h155, 10'd0, 1'b1);
        issue(0, 1'b0, 3'd0, 3'd1, 3'd0, 10'd0,   10'd0,   10'd2, 1'b0);

        // Withdrawal: req1 valid for one cycle during req0's ACCESS only.
        fork
            issue(0, 1'b0, 3'd2, 3'd3, 3'd0, 10'd0, 10'd4, 10'h155, 1'b0);
            begin
                wait_ready0(ok);
                @(posedge clk); #1 req1_we = 1'b0; req1_rs1 = 3'd7; req1_valid = 1'b1;
                @(posedge clk); #1 req1_valid = 1'b0;
            end
        join
        repeat (6) @(posedge clk);

        // Contention from reset: strict alternation, one accept every 3 cycles.
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        acc_id.delete(); acc_cyc.delete();
        fork
            for (int i = 0; i < 6; i++) issue(0, 1'b0, 3'd4, 3'd5, 3'd0, 10'd0, 10'd8, 10'd10, 1'b0);
            for (int j = 0; j < 6; j++) issue(1, 1'b0, 3'd6, 3'd7, 3'd0, 10'd0, 10'd12, 10'd14, 1'b0);
        join
        chk("t4_accepts", acc_id.size(), 32'd12);
        for (int k = 0; k < acc_id.size(); k++) begin
            chk($sformatf("t4_order_%0d", k), acc_id[k], k % 2);
            if (k > 0) chk($sformatf("t4_gap_%0d", k), acc_cyc[k] - acc_cyc[k-1], 32'd3);
        end

        for (int i = 0; i < 10 && (q0.size() + q1.size()) != 0; i++) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
